// File: rtl/nios2_computer_leds_shifter.sv
// Serialises the parallel LED port value into a 74HC595-style shift/latch register.
// All outputs are registered; a transfer runs LOAD -> (SHIFT_LO, SHIFT_HI) x WIDTH -> LATCH.
module nios2_computer_leds_shifter #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             refresh,
  output logic             sr_data,
  output logic             sr_clk,
  output logic             sr_latch,
  output logic             busy
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH
  } state_t;

  state_t           r_state;
  logic [DW-1:0]    r_div_cnt;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_sent;
  logic             r_refresh_pending;
  logic             r_init_pending;
  logic             r_sr_data;
  logic             r_sr_clk;
  logic             r_sr_latch;
  logic             r_busy;

  logic             w_tick;
  logic             w_trigger;
  logic [WIDTH-1:0] w_shift_next;
  logic             w_first_bit;
  logic             w_next_bit;

  assign w_tick       = (r_div_cnt == DIV_LAST);
  // A refresh seen in IDLE starts LOAD on the very next cycle, not one later via the pending flag.
  assign w_trigger    = (data_in != r_sent) || r_refresh_pending || r_init_pending || refresh;
  assign w_shift_next = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
  assign w_first_bit  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
  assign w_next_bit   = MSB_FIRST ? w_shift_next[WIDTH-1] : w_shift_next[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= S_IDLE;
      r_div_cnt         <= '0;
      r_bit_cnt         <= '0;
      r_shift           <= '0;
      r_sent            <= '0;
      r_refresh_pending <= 1'b0;
      r_init_pending    <= 1'b1;
      r_sr_data         <= 1'b0;
      r_sr_clk          <= 1'b0;
      r_sr_latch        <= 1'b0;
      r_busy            <= 1'b0;
    end else begin
      if (refresh) begin
        r_refresh_pending <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_div_cnt <= '0;
          if (w_trigger) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_shift           <= data_in;
          r_sent            <= data_in;
          // A refresh landing in this very cycle must survive the clear.
          r_refresh_pending <= refresh;
          r_init_pending    <= 1'b0;
          r_bit_cnt         <= CNT_FULL;
          r_sr_data         <= w_first_bit;
          r_div_cnt         <= '0;
          r_state           <= S_SHIFT_LO;
        end
        S_SHIFT_LO: begin
          if (w_tick) begin
            r_div_cnt <= '0;
            r_sr_clk  <= 1'b1;
            r_state   <= S_SHIFT_HI;
          end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
          end
        end
        S_SHIFT_HI: begin
          if (w_tick) begin
            r_div_cnt <= '0;
            r_sr_clk  <= 1'b0;
            r_bit_cnt <= r_bit_cnt - CNT_ONE;
            if (r_bit_cnt == CNT_ONE) begin
              r_sr_latch <= 1'b1;
              r_state    <= S_LATCH;
            end else begin
              r_shift   <= w_shift_next;
              r_sr_data <= w_next_bit;
              r_state   <= S_SHIFT_LO;
            end
          end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
          end
        end
        S_LATCH: begin
          if (w_tick) begin
            r_div_cnt  <= '0;
            r_sr_latch <= 1'b0;
            r_sr_data  <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
          end
        end
        default: begin
          r_div_cnt  <= '0;
          r_sr_clk   <= 1'b0;
          r_sr_latch <= 1'b0;
          r_sr_data  <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign sr_data  = r_sr_data;
  assign sr_clk   = r_sr_clk;
  assign sr_latch = r_sr_latch;
  assign busy     = r_busy;

endmodule

// File: tb/tb_nios2_computer_leds_shifter.sv
// Bench for the serial LED shifter: a 595 model per instance feeds a scoreboard of expected latched values.
// dut drives defaults (MSB first, CLK_DIV=4); dut2 runs LSB first with CLK_DIV=1.
module tb_nios2_computer_leds_shifter;

  logic       clk = 1'b0;
  logic       reset_n, refresh, reset2_n, refresh2;
  logic [7:0] data_in, data_in2;
  logic       sr_data, sr_clk, sr_latch, busy;
  logic       sr_data2, sr_clk2, sr_latch2, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios2_computer_leds_shifter #(.WIDTH(8), .CLK_DIV(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .refresh(refresh),
    .sr_data(sr_data), .sr_clk(sr_clk), .sr_latch(sr_latch), .busy(busy)
  );

  nios2_computer_leds_shifter #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .reset_n(reset2_n), .data_in(data_in2), .refresh(refresh2),
    .sr_data(sr_data2), .sr_clk(sr_clk2), .sr_latch(sr_latch2), .busy(busy2)
  );

  // Scoreboards: expected latched values, pushed when stimulus is driven.
  logic [7:0] sb_q[$];
  logic [7:0] sb2_q[$];

  // 595 model and transfer statistics for dut.
  logic [7:0] sh;
  bit         bits_q[$];
  logic       p_clk = 1'b0, p_latch = 1'b0, p_busy = 1'b0;
  int         busy_cnt = 0, last_busy_len = 0, latch_cnt = 0, last_latch_len = 0;
  int         rise_cnt = 0, xfer_count = 0;

  // Same for dut2; bits arrive LSB first so the model shifts towards bit 0.
  logic [7:0] sh2;
  bit         bits2_q[$];
  logic       p_clk2 = 1'b0, p_latch2 = 1'b0, p_busy2 = 1'b0;
  int         busy2_cnt = 0, last_busy2_len = 0, latch2_cnt = 0, last_latch2_len = 0;
  int         xfer2_count = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      p_clk = 1'b0; p_latch = 1'b0; p_busy = 1'b0;
    end else begin
      if (busy && !p_busy) begin
        busy_cnt = 0; rise_cnt = 0; bits_q.delete();
      end
      if (busy) busy_cnt++;
      if (!busy && p_busy) last_busy_len = busy_cnt;
      if (sr_clk && !p_clk) begin
        sh = {sh[6:0], sr_data};
        bits_q.push_back(sr_data);
        rise_cnt++;
      end
      if (sr_latch && !p_latch) latch_cnt = 0;
      if (sr_latch) latch_cnt++;
      if (!sr_latch && p_latch) begin
        last_latch_len = latch_cnt;
        xfer_count++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: latched %h, expected no transfer", sh);
        end else begin
          logic [7:0] exp_v;
          exp_v = sb_q.pop_front();
          if (sh !== exp_v) begin
            errors++;
            $display("FAIL sb_latch: latched %h, expected %h", sh, exp_v);
          end
        end
        $display("dut  transfer %0d latched %h busy %0d cycles latch %0d cycles",
                 xfer_count, sh, last_busy_len, last_latch_len);
      end
      p_clk = sr_clk; p_latch = sr_latch; p_busy = busy;
    end
  end

  always @(negedge clk) begin
    if (!reset2_n) begin
      p_clk2 = 1'b0; p_latch2 = 1'b0; p_busy2 = 1'b0;
    end else begin
      if (busy2 && !p_busy2) begin
        busy2_cnt = 0; bits2_q.delete();
      end
      if (busy2) busy2_cnt++;
      if (!busy2 && p_busy2) last_busy2_len = busy2_cnt;
      if (sr_clk2 && !p_clk2) begin
        sh2 = {sr_data2, sh2[7:1]};
        bits2_q.push_back(sr_data2);
      end
      if (sr_latch2 && !p_latch2) latch2_cnt = 0;
      if (sr_latch2) latch2_cnt++;
      if (!sr_latch2 && p_latch2) begin
        last_latch2_len = latch2_cnt;
        xfer2_count++;
        checks++;
        if (sb2_q.size() == 0) begin
          errors++;
          $display("FAIL sb2_unexpected: latched %h, expected no transfer", sh2);
        end else begin
          logic [7:0] exp_v;
          exp_v = sb2_q.pop_front();
          if (sh2 !== exp_v) begin
            errors++;
            $display("FAIL sb2_latch: latched %h, expected %h", sh2, exp_v);
          end
        end
        $display("dut2 transfer %0d latched %h busy %0d cycles latch %0d cycles",
                 xfer2_count, sh2, last_busy2_len, last_latch2_len);
      end
      p_clk2 = sr_clk2; p_latch2 = sr_latch2; p_busy2 = busy2;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_xfers(input int target, input int budget, input string name);
    int n = 0;
    while (xfer_count < target && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (xfer_count < target) begin
      errors++;
      $display("FAIL %s_timeout: transfers %0d, required %0d within %0d cycles", name, xfer_count, target, budget);
    end
  endtask

  task automatic wait_rises(input int target, input int budget, input string name);
    int n = 0;
    while (rise_cnt < target && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (rise_cnt < target) begin
      errors++;
      $display("FAIL %s_rises: sr_clk rises %0d, required %0d within %0d cycles", name, rise_cnt, target, budget);
    end
  endtask

  function automatic logic [7:0] bits_word(input int which);
    logic [7:0] w = 8'h00;
    if (which == 0) foreach (bits_q[i]) w = {w[6:0], bits_q[i]};
    else            foreach (bits2_q[i]) w = {w[6:0], bits2_q[i]};
    return w;
  endfunction

  task automatic test_reset();
    int base;
    reset_n = 1'b0; reset2_n = 1'b0; refresh = 1'b0; refresh2 = 1'b0;
    data_in = 8'h00; data_in2 = 8'h00; sh = 8'h00; sh2 = 8'h00;
    repeat (3) step();
    checks++;
    if ({sr_data, sr_clk, sr_latch, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: data/clk/latch/busy=%b, required 0000", {sr_data, sr_clk, sr_latch, busy});
    end
    checks++;
    if ({sr_data2, sr_clk2, sr_latch2, busy2} !== 4'b0000) begin
      errors++;
      $display("FAIL reset2_outputs: data/clk/latch/busy=%b, required 0000", {sr_data2, sr_clk2, sr_latch2, busy2});
    end
    base = xfer_count;
    sb_q.push_back(8'h00);
    sb2_q.push_back(8'h00);
    reset_n = 1'b1; reset2_n = 1'b1;
    wait_xfers(base + 1, 200, "init");
    checks++;
    if (last_busy_len != 69) begin
      errors++; $display("FAIL init_busy_len: %0d cycles, required 69", last_busy_len);
    end
    checks++;
    if (rise_cnt != 8) begin
      errors++; $display("FAIL init_rises: %0d, required 8", rise_cnt);
    end
    checks++;
    if (last_latch_len != 4) begin
      errors++; $display("FAIL init_latch_len: %0d cycles, required 4", last_latch_len);
    end
    repeat (50) step();
    checks++;
    if (xfer_count != base + 1 || busy !== 1'b0) begin
      errors++; $display("FAIL init_quiet: transfers %0d busy %b, required %0d and 0", xfer_count, busy, base + 1);
    end
  endtask

  task automatic test_pattern();
    int base = xfer_count;
    data_in = 8'hA5;
    sb_q.push_back(8'hA5);
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL a5_load_latency: busy=%b one cycle after change, required 1", busy);
    end
    wait_xfers(base + 1, 200, "a5");
    checks++;
    if (bits_q.size() != 8 || bits_word(0) !== 8'b1010_0101) begin
      errors++; $display("FAIL a5_bits: %0d bits %b, required 8 bits 10100101", bits_q.size(), bits_word(0));
    end
  endtask

  task automatic test_drop_intermediate();
    int base = xfer_count;
    data_in = 8'h01;
    sb_q.push_back(8'h01);
    step();
    wait_rises(2, 100, "drop");
    data_in = 8'h02;
    repeat (5) step();
    data_in = 8'h04;
    sb_q.push_back(8'h04);
    wait_xfers(base + 2, 400, "drop");
    repeat (30) step();
    checks++;
    if (xfer_count != base + 2) begin
      errors++; $display("FAIL drop_count: %0d transfers, required %0d", xfer_count - base, 2);
    end
  endtask

  task automatic test_refresh();
    int base = xfer_count;
    data_in = 8'h3C;
    sb_q.push_back(8'h3C);
    wait_xfers(base + 1, 200, "refresh_setup");
    repeat (3) step();
    refresh = 1'b1;
    sb_q.push_back(8'h3C);
    step();
    refresh = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL refresh_load_latency: busy=%b, required 1", busy);
    end
    for (int k = 0; k < 3; k++) begin
      repeat (10) step();
      refresh = 1'b1;
      step();
      refresh = 1'b0;
    end
    sb_q.push_back(8'h3C);
    wait_xfers(base + 3, 400, "refresh");
    repeat (100) step();
    checks++;
    if (xfer_count != base + 3) begin
      errors++; $display("FAIL refresh_count: %0d transfers, required 3", xfer_count - base);
    end
  endtask

  task automatic test_reset_midxfer();
    int base;
    data_in = 8'hFF;
    sb_q.push_back(8'hFF);
    step();
    wait_rises(3, 100, "midrst");
    base = xfer_count;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sr_data, sr_clk, sr_latch, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_async: data/clk/latch/busy=%b, required 0000", {sr_data, sr_clk, sr_latch, busy});
    end
    repeat (5) step();
    checks++;
    if (xfer_count != base || sr_latch !== 1'b0) begin
      errors++; $display("FAIL midrst_no_latch: transfers %0d latch %b, required %0d and 0", xfer_count, sr_latch, base);
    end
    reset_n = 1'b1;
    wait_xfers(base + 1, 200, "midrst");
    checks++;
    if (last_busy_len != 69) begin
      errors++; $display("FAIL midrst_busy_len: %0d cycles, required 69", last_busy_len);
    end
  endtask

  task automatic test_lsb_fast();
    int base = xfer2_count;
    int n = 0;
    data_in2 = 8'h80;
    sb2_q.push_back(8'h80);
    step();
    checks++;
    if (busy2 !== 1'b1) begin
      errors++; $display("FAIL lsb_load_latency: busy2=%b, required 1", busy2);
    end
    while (xfer2_count < base + 1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (xfer2_count != base + 1) begin
      errors++; $display("FAIL lsb_timeout: %0d transfers, required 1", xfer2_count - base);
    end
    checks++;
    if (bits2_q.size() != 8 || bits_word(1) !== 8'b0000_0001) begin
      errors++; $display("FAIL lsb_bits: %0d bits %b, required 8 bits 00000001", bits2_q.size(), bits_word(1));
    end
    checks++;
    if (last_busy2_len != 18) begin
      errors++; $display("FAIL lsb_busy_len: %0d cycles, required 18", last_busy2_len);
    end
    checks++;
    if (last_latch2_len != 1) begin
      errors++; $display("FAIL lsb_latch_len: %0d cycles, required 1", last_latch2_len);
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_drop_intermediate();
    test_refresh();
    test_reset_midxfer();
    test_lsb_fast();
    checks++;
    if (sb_q.size() != 0 || sb2_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d and %0d pending, required 0 and 0", sb_q.size(), sb2_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nios2_computer_leds_shifter.md
Name: nios2_computer_leds_shifter

Overview:
Serial LED driver downstream of the 8-bit LED output port. Consumes the port's parallel out_port value and serialises it to an external 74HC595-style shift/latch register (data, shift clock, storage latch). A new transfer starts on any value change, on an explicit refresh request, or once after reset. This frees board pins and keeps the processor-side PIO unchanged.

Parameters:
WIDTH, 8, number of LED bits serialised per transfer (must be >= 1).
CLK_DIV, 4, clk cycles per sr_clk half-period, latch pulse width (must be >= 1).
MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first, 0 = bit 0 first.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
data_in  input  WIDTH  parallel LED value, driven by PIO out_port
refresh  input  1  single-cycle request to re-send current value
sr_data  output  1  serial data to shift register
sr_clk  output  1  shift clock; register samples sr_data on rising edge
sr_latch  output  1  storage-register latch pulse, active high
busy  output  1  transfer in progress

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on reset_n.
- Reset: sr_data=0, sr_clk=0, sr_latch=0, busy=0, FSM=IDLE, divider=0, sent_value=0.
- Reset also sets init_pending=1, which forces one transfer after release.
- All outputs come straight from flops, so they are glitch-free.
- Divider: div_cnt counts 0..CLK_DIV-1. A tick occurs when div_cnt==CLK_DIV-1. div_cnt clears on every state change.
- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE: sr_clk=0, sr_latch=0, sr_data=0, busy=0.
  - Trigger condition: (data_in != sent_value) or refresh_pending or init_pending.
  - On trigger, go to LOAD next cycle.
- LOAD (1 cycle):
  - Copy data_in into shift_reg and sent_value.
  - Clear refresh_pending and init_pending.
  - Set bit_cnt=WIDTH.
  - Drive sr_data with the first bit (MSB if MSB_FIRST, else LSB).
  - busy=1.
  - Go to SHIFT_LO.
- SHIFT_LO: sr_clk=0 for CLK_DIV cycles. On tick: sr_clk<=1, go to SHIFT_HI.
- SHIFT_HI: sr_clk=1 for CLK_DIV cycles. On tick:
  - sr_clk<=0 and bit_cnt decrements.
  - If bit_cnt was 1, go to LATCH.
  - Otherwise shift shift_reg, drive the next bit on sr_data, and go to SHIFT_LO.
  - sr_data therefore changes only on the sr_clk falling edge, giving CLK_DIV cycles of setup and hold.
- LATCH: sr_clk=0, sr_latch=1 for CLK_DIV cycles. On tick: sr_latch<=0, go to IDLE.
- busy is high from LOAD through LATCH inclusive.
- Transfer length is 1 + 2*WIDTH*CLK_DIV + CLK_DIV cycles. With defaults this is 69 cycles.
- Back-to-back transfers have at least 1 IDLE cycle between the LATCH end and the next LOAD.
- data_in changes while busy:
  - Changes are not sampled mid-transfer.
  - After IDLE, the latest data_in is compared against sent_value. Intermediate values are dropped; only the final value is sent.
  - If data_in returns to sent_value before IDLE, no extra transfer occurs.
- refresh:
  - A refresh in any state sets refresh_pending.
  - A refresh in IDLE triggers LOAD next cycle.
  - Multiple refreshes while busy collapse to one follow-up transfer.
  - A refresh coinciding with a data_in change gives one transfer.
  - A refresh asserted in the LOAD cycle itself causes one follow-up transfer (set wins over clear).
- Reset asserted mid-transfer: all outputs go to their reset values immediately (asynchronous). A partial shift is never latched, and a full transfer follows release.

Test Plan:
1. Release reset, data_in=0x00, defaults -> exactly one transfer: busy high 69 cycles, 8 sr_clk rising edges, one sr_latch pulse 4 cycles wide, then idle with no further activity.
2. data_in 0x00->0xA5 in IDLE -> LOAD next cycle; bits sampled at sr_clk rises = 1,0,1,0,0,1,0,1; 595 model holds 0xA5 after sr_latch falls.
3. Mid-transfer of 0x01, set data_in 0x02 then 0x04 -> exactly two transfers total (0x01, then 0x04); 0x02 never appears on the serial line.
4. data_in steady 0x3C, refresh pulse in IDLE -> one retransmit of 0x3C. Three refresh pulses during that busy period -> exactly one further transfer.
5. Assert reset_n after the 3rd sr_clk rise of 0xFF -> outputs 0 same cycle, no sr_latch pulse. Release -> full transfer of 0xFF, latched.
6. MSB_FIRST=0, CLK_DIV=1, data_in=0x80 -> bits 0,0,0,0,0,0,0,1, busy 18 cycles, sr_latch 1 cycle wide.
